// File: rtl/snes_pad_responder_pkg.sv
// Shared definitions for the SNES/NES pad responder: button indices,
// frame sizes, FSM state encoding and frame-load helpers.
package snes_pkg;

    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

    localparam int unsigned SNES_FRAME_BITS = 16;
    localparam int unsigned NES_FRAME_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } snes_resp_state_t;

    // SNES frame image: active-low buttons in bits 0..11, unused bits released.
    function automatic logic [15:0] snes_load(input logic [11:0] btn);
        return {4'hF, ~btn};
    endfunction

    // NES frame image: A,B,Select,Start,Up,Down,Left,Right, active-low.
    function automatic logic [7:0] nes_load(input logic [11:0] btn);
        return ~{btn[BTN_RIGHT], btn[BTN_LEFT], btn[BTN_DOWN], btn[BTN_UP],
                 btn[BTN_START], btn[BTN_SELECT], btn[BTN_B], btn[BTN_A]};
    endfunction

endpackage

// File: rtl/snes_pad_responder_if.sv
// Serial pad link: host drives latch and shift clock, pad returns data.
interface snes_pad_responder_if;
    logic NStrobe_Latch;
    logic NShift_Clock;
    logic SNESData;

    modport master (output NStrobe_Latch, output NShift_Clock, input SNESData);
    modport slave  (input NStrobe_Latch, input NShift_Clock, output SNESData);
endinterface

// File: rtl/snes_pad_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous host line with registered
// rise/fall pulses. Resets to 1 (idle host level) so no spurious edge on release.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise_q;
    logic                   fall_q;

    // Shift the async input through the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    // Edge pulses line up with the cycle in which the last stage changes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Pad-side end of the SNES/NES serial controller link: latches button
// state on the host strobe and shifts it out, one bit per shift-clock rise.
module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                Clock,
    input  logic                NReset,
    input  logic [11:0]         Buttons,
    snes_pad_responder_if.slave link,
    output logic                Frame_Done,
    output logic [4:0]          Bit_Index
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS);

    snes_resp_state_t        state_q, state_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [4:0]              idx_q, idx_d;
    logic                    done_q, done_d;
    logic [FRAME_BITS-1:0]   load_s;

    logic latch_sync_s, latch_rise_s, latch_fall_s;
    logic shift_sync_s, shift_rise_s, shift_fall_s;
    logic unused_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk_i   (Clock),
        .rst_n_i (NReset),
        .async_i (link.NStrobe_Latch),
        .sync_o  (latch_sync_s),
        .rise_o  (latch_rise_s),
        .fall_o  (latch_fall_s)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_shift_sync (
        .clk_i   (Clock),
        .rst_n_i (NReset),
        .async_i (link.NShift_Clock),
        .sync_o  (shift_sync_s),
        .rise_o  (shift_rise_s),
        .fall_o  (shift_fall_s)
    );

    // Latch is acted on by level; the remaining edge/level taps are not needed.
    assign unused_s = &{1'b0, latch_fall_s, shift_sync_s, shift_fall_s};

    // Frame image from the live buttons, in SNES or NES bit order.
    if (FRAME_BITS == NES_FRAME_BITS) begin : g_nes
        assign load_s = nes_load(Buttons);
    end else begin : g_snes
        assign load_s = snes_load(Buttons);
    end

    // FSM state register.
    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: an active latch always wins over a pending shift edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!latch_sync_s) state_d = ST_LATCH;
                else               state_d = ST_IDLE;
            end
            ST_LATCH: begin
                if (latch_rise_s) state_d = ST_SHIFT;
                else              state_d = ST_LATCH;
            end
            ST_SHIFT: begin
                if (!latch_sync_s)                                 state_d = ST_LATCH;
                else if (shift_rise_s && (idx_q == LAST_IDX - 5'd1)) state_d = ST_DONE;
                else                                               state_d = ST_SHIFT;
            end
            ST_DONE: begin
                if (!latch_sync_s) state_d = ST_LATCH;
                else               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: reload while latching, shift on each advance.
    always_comb begin
        sr_d   = sr_q;
        idx_d  = idx_q;
        done_d = (state_q == ST_SHIFT) && (state_d == ST_DONE);
        if ((state_d == ST_LATCH) || (state_q == ST_LATCH)) begin
            sr_d  = load_s;
            idx_d = 5'd0;
        end else if ((state_q == ST_SHIFT) && shift_rise_s) begin
            sr_d  = {1'b0, sr_q[FRAME_BITS-1:1]};
            idx_d = idx_q + 5'd1;
        end else begin
            sr_d  = sr_q;
            idx_d = idx_q;
        end
    end

    // Datapath registers; SNESData is taken straight from shift-register bit 0.
    always_ff @(posedge Clock or negedge NReset) begin
        if (!NReset) begin
            sr_q   <= {FRAME_BITS{1'b1}};
            idx_q  <= 5'd0;
            done_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign link.SNESData = sr_q[0];
    assign Frame_Done    = done_q;
    assign Bit_Index     = idx_q;

endmodule
